spike_aer_encoder: RTL
======================

SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 Parameter NR_DEPTH, default 16, neuron count; index width is clog2(NR_DEPTH).
REQ-002 Parameter TIME_WIDTH, default 16, timestep counter width.
REQ-003 Parameter FIFO_DEPTH, default 8, event buffer entries, power of two, minimum 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 output_occurred  input  1  neuron fired this cycle; qualifies output_index.
REQ-007 output_index  input  clog2(NR_DEPTH)  index of the firing neuron.
REQ-008 step_done  input  1  one-cycle pulse marking the end of a network timestep.
REQ-009 overflow_clr  input  1  clears the overflow flag.
REQ-010 aer_ready  input  1  downstream accepts the AER word.
REQ-011 aer_valid  output  1  aer_data holds a valid event.
REQ-012 aer_data  output  TIME_WIDTH+clog2(NR_DEPTH)  packet {timestamp, neuron index}, timestamp in the MSBs.
REQ-013 time_count  output  TIME_WIDTH  current timestep number.
REQ-014 fifo_level  output  clog2(FIFO_DEPTH)+1  occupied entries.
REQ-015 overflow  output  1  sticky flag: an event was dropped.

Function
REQ-016 time_count SHALL increment by 1 on each clock with step_done high and wrap from 2^TIME_WIDTH-1 to 0.
REQ-017 An event with output_occurred high SHALL be stamped with the time_count value before any same-cycle step_done increment.
REQ-018 An accepted event SHALL be written to the FIFO in the cycle it occurs.
REQ-019 When the FIFO was empty, aer_valid SHALL rise in the next cycle (latency 1).
REQ-020 aer_data SHALL come from a register, driven by the FIFO head, and SHALL be delivered in arrival order.
REQ-021 While aer_valid is high and aer_ready is low, aer_valid and aer_data SHALL stay stable.
REQ-022 A transfer SHALL occur on each clock with aer_valid and aer_ready both high; the next entry SHALL be presented in the following cycle with no bubble.
REQ-023 aer_valid SHALL be low whenever the FIFO is empty; aer_ready in that state SHALL have no effect.
REQ-024 When the FIFO is full and no pop occurs, the incoming event SHALL be dropped and overflow SHALL be set.
REQ-025 When the FIFO is full and a pop occurs in the same cycle, the incoming event SHALL be accepted and no overflow SHALL be flagged.
REQ-026 Simultaneous push and pop at any level SHALL leave fifo_level unchanged.
REQ-027 overflow_clr SHALL clear overflow; if a drop occurs in the same cycle, set SHALL win.
REQ-028 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL distinguish full from empty.

Reset
REQ-029 Asserting reset SHALL immediately set aer_valid=0, aer_data=0, time_count=0, fifo_level=0 and overflow=0, and empty both pointers.
REQ-030 Reset asserted mid-operation SHALL discard all buffered events; the first event after deassertion SHALL carry timestamp 0.
REQ-031 FIFO storage contents need no reset.

Structure
REQ-032 A shared package SHALL hold the aer_event_t packed struct {timestamp, index} and the default NR_DEPTH, TIME_WIDTH and FIFO_DEPTH constants.
REQ-033 The buffer SHALL be a single sub-module, aer_fifo: synchronous, parameterised width and depth, with push/pop/full/empty/level.

Verification
REQ-034 Single event: fire index 5 with time_count=0 -> next cycle aer_valid=1, aer_data={16'd0,4'd5}.
REQ-035 Fire index 3 and step_done in the same cycle with time_count=7 -> packet {7,3}; time_count becomes 8.
REQ-036 Backpressure: 8 events with aer_ready=0 -> fifo_level=8 and aer_data stable; 9th event -> dropped, overflow=1; then aer_ready=1 -> 8 words in order, one per cycle.
REQ-037 Full with simultaneous pop and push -> level stays 8 and overflow stays 0; overflow_clr together with a drop -> overflow stays 1.
REQ-038 Wrap: 65535 step_done pulses then one more -> time_count=0; an event in that cycle carries timestamp 65535.
REQ-039 Reset asserted with 4 events queued -> aer_valid drops immediately, fifo_level=0; after release, fire index 1 -> packet {0,1}.

Source files
------------

// File: rtl/spike_aer_encoder_pkg.sv
// Shared types and default sizing for the spike AER encoder.
// aer_event_t is the {timestamp, index} word carried on the AER bus.
package spike_aer_encoder_pkg;

    localparam int NR_DEPTH_DEF   = 16;
    localparam int TIME_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int IDX_WIDTH_DEF  = $clog2(NR_DEPTH_DEF);

    typedef struct packed {
        logic [TIME_WIDTH_DEF-1:0] timestamp;
        logic [IDX_WIDTH_DEF-1:0]  index;
    } aer_event_t;

endpackage

// File: rtl/aer_fifo.sv
// Synchronous FIFO with a registered head output.
// dout is loaded with the entry that will be at the head after each edge.
module aer_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE        = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      level_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == FULL_LEVEL);
    assign do_pop  = pop && !empty;
    // A full buffer still takes a new entry when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + AW'(do_pop);

    // Bypass when the new head is the slot being written right now.
    assign head_next = (do_push && (rd_next == wr_ptr)) ? din : mem[rd_next];

    always_comb begin
        level_next = level;
        unique case ({do_push, do_pop})
            2'b10:   level_next = level + ONE;
            2'b01:   level_next = level - ONE;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_ptr + AW'(do_push);
            level  <= level_next;
            dout   <= (level_next != '0) ? head_next : '0;
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Stamps neuron spikes with the current timestep and queues them
// as {timestamp, index} words on a valid/ready AER output.
module spike_aer_encoder
    import spike_aer_encoder_pkg::*;
#(
    parameter int NR_DEPTH   = NR_DEPTH_DEF,
    parameter int TIME_WIDTH = TIME_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int IW = $clog2(NR_DEPTH),
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   output_occurred,
    input  logic [IW-1:0]          output_index,
    input  logic                   step_done,
    input  logic                   overflow_clr,
    input  logic                   aer_ready,
    output logic                   aer_valid,
    output logic [TIME_WIDTH+IW-1:0] aer_data,
    output logic [TIME_WIDTH-1:0]  time_count,
    output logic [LW-1:0]          fifo_level,
    output logic                   overflow
);

    logic [TIME_WIDTH+IW-1:0] event_word;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     drop;

    // The stamp uses the pre-increment count when step_done coincides.
    assign event_word = {time_count, output_index};
    assign aer_valid  = !fifo_empty;
    assign drop       = output_occurred && fifo_full && !aer_ready;

    aer_fifo #(
        .WIDTH (TIME_WIDTH + IW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (output_occurred),
        .din   (event_word),
        .pop   (aer_ready),
        .dout  (aer_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            time_count <= '0;
        end else if (step_done) begin
            time_count <= time_count + TIME_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
